hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit that sits directly upstream of the Hi/Lo register file.
- Takes two 32-bit operands from the ALU operand path and computes a 64-bit product, or a quotient and remainder, at one bit per cycle.
- Presents the result as separate Hi/Lo words, with a single-cycle write strobe, multiply-accumulate strobe or multiply-subtract strobe for the Hi/Lo register file.
- Busy output stalls the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; Hi and Lo are each WIDTH bits.
- ITER, 32, number of RUN cycles (one result bit per cycle); must equal WIDTH.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  request new operation; sampled only when not Busy
- Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB; 110/111 illegal
- A  input  WIDTH  operand rs (multiplicand / dividend)
- B  input  WIDTH  operand rt (multiplier / divisor)
- Busy  output  1  high while an accepted operation is in progress
- Done  output  1  one-cycle pulse when result is valid
- HiOut  output  WIDTH  product[63:32] or remainder
- LoOut  output  WIDTH  product[31:0] or quotient
- WriteEn  output  1  one-cycle pulse with Done for MULT/MULTU/DIV/DIVU
- Madd  output  1  one-cycle pulse with Done for MADD
- Msub  output  1  one-cycle pulse with Done for MSUB
- DivByZero  output  1  valid with Done; high if a divide had B==0

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - All outputs go to 0 immediately (Busy, Done, HiOut, LoOut, WriteEn, Madd, Msub, DivByZero).
  - Reset mid-operation aborts it with no strobe issued.
- States: IDLE, RUN, FINISH.
- IDLE:
  - On Start=1 with a legal Op, latch Op, A, B and operand signs.
  - Signed ops (MULT, DIV, MADD, MSUB) convert A and B to magnitudes; unsigned ops use them raw.
  - Clear the accumulator and iteration counter, then go to RUN.
  - Illegal Op or Start=0: stay in IDLE with no effect.
- RUN:
  - Multiply is shift-add on 64-bit magnitudes; divide is restoring, one quotient bit per cycle.
  - Counter increments each cycle; after ITER cycles go to FINISH.
- FINISH:
  - Apply the sign fix: product negated if the signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
  - Register HiOut/LoOut, go to IDLE, and assert Done plus exactly one strobe for the following cycle.
- Latency:
  - Start sampled at edge E0; Busy=1 from E0 until E34.
  - Done, the strobe and the results are visible in the cycle following E34, i.e. Done asserts 34 cycles after Start is accepted.
- Busy is low in the Done cycle. A Start in that cycle is accepted (back-to-back issue).
- HiOut/LoOut hold their last result until the next FINISH. Done, WriteEn, Madd and Msub are single-cycle pulses.
- Start while Busy=1 is ignored. A and B changing while Busy has no effect.
- Divide by zero:
  - Full latency still applies; DivByZero=1, HiOut=A as latched, LoOut=all-ones, WriteEn pulses.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): LoOut=0x80000000, HiOut=0, DivByZero=0.
- MADD/MSUB: HiOut/LoOut carry the signed 64-bit product. Accumulation into Hi/Lo is performed by the consumer on the Madd/Msub pulse.
- All arithmetic is modulo 2^64 for products and modulo 2^32 for quotient/remainder; no saturation.

Test Plan:
- MULT, A=0xFFFFFFFD (-3), B=5 -> Done after 34 cycles; HiOut=0xFFFFFFFF, LoOut=0xFFFFFFF1, WriteEn=1 for one cycle, Madd=Msub=0.
- MULTU, A=B=0xFFFFFFFF -> HiOut=0xFFFFFFFE, LoOut=0x00000001. Then MADD, A=2, B=3 -> HiOut=0, LoOut=6, Madd pulse only.
- DIV, A=0xFFFFFFF9 (-7), B=2 -> LoOut=0xFFFFFFFD, HiOut=0xFFFFFFFF. Then DIVU, A=7, B=2 -> LoOut=3, HiOut=1.
- DIVU, A=0x1234, B=0 -> DivByZero=1, HiOut=0x1234, LoOut=0xFFFFFFFF. Then DIV, A=0x80000000, B=0xFFFFFFFF -> LoOut=0x80000000, HiOut=0.
- MSUB, A=4, B=4, with a second Start (MULT, A=9, B=9) pulsed 10 cycles later -> second Start ignored; single Msub pulse with LoOut=16; a Start in the Done cycle is accepted and yields LoOut=81 34 cycles later.
- MULT started, Reset asserted mid-cycle at RUN iteration 15 -> all outputs 0 immediately, no strobe ever issued. After Reset deasserts, the unit accepts a new Start normally.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit feeding the Hi/Lo register file.
// It produces one result bit per cycle. Products are formed by shift-add
// on magnitudes, and quotient/remainder by restoring division. The sign
// fix and the Hi/Lo strobes are applied in a final FINISH cycle.
module hilo_muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] HiOut,
   output logic [WIDTH-1:0] LoOut,
   output logic             WriteEn,
   output logic             Madd,
   output logic             Msub,
   output logic             DivByZero
);

   localparam int CW = $clog2(ITER + 1);
   localparam logic [CW-1:0] LAST_COUNT = CW'(ITER);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MADD  = 3'b100;
   localparam logic [2:0] OP_MSUB  = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FINISH
   } stateType;

   stateType state;
   stateType nextState;

   logic [2:0]         opReg;
   logic [WIDTH-1:0]   aLatched;
   logic               signA;
   logic               signB;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   divisor;
   logic [CW-1:0]      count;

   logic               accept;
   logic               opSigned;
   logic               inSignA;
   logic               inSignB;
   logic [WIDTH-1:0]   magA;
   logic [WIDTH-1:0]   magB;
   logic               isDivOp;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     trial;
   logic [2*WIDTH-1:0] prodFixed;
   logic [WIDTH-1:0]   resultHi;
   logic [WIDTH-1:0]   resultLo;
   logic               resultDbz;

   // Operand decode at issue time: legality, signedness and magnitudes.
   always_comb begin
      opSigned = (Op != OP_MULTU) && (Op != OP_DIVU);
      accept   = (state == IDLE) && Start && (Op <= OP_MSUB);
      inSignA  = opSigned && A[WIDTH-1];
      inSignB  = opSigned && B[WIDTH-1];
      magA     = inSignA ? (~A + 1'b1) : A;
      magB     = inSignB ? (~B + 1'b1) : B;
   end

   // One restoring-division step: shift in the next dividend bit and try
   // subtracting the divisor. A clear borrow bit means the subtraction fits.
   always_comb begin
      isDivOp = (opReg == OP_DIV) || (opReg == OP_DIVU);
      shifted = {rem, quo[WIDTH-1]};
      trial   = shifted - {1'b0, divisor};
   end

   // Final sign correction and special cases, consumed in FINISH.
   // Divide by zero returns the dividend as latched and an all-ones
   // quotient, independent of the operand signs.
   always_comb begin
      resultHi  = '0;
      resultLo  = '0;
      resultDbz = 1'b0;
      prodFixed = (signA ^ signB) ? (~acc + 1'b1) : acc;
      if (isDivOp) begin
         if (divisor == '0) begin
            resultHi  = aLatched;
            resultLo  = '1;
            resultDbz = 1'b1;
         end else begin
            resultLo = (signA ^ signB) ? (~quo + 1'b1) : quo;
            resultHi = signA ? (~rem + 1'b1) : rem;
         end
      end else begin
         resultHi = prodFixed[2*WIDTH-1:WIDTH];
         resultLo = prodFixed[WIDTH-1:0];
      end
   end

   // State register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. RUN spends ITER cycles producing result bits plus
   // one cycle with the counter at ITER, so Done lands 34 cycles after issue.
   always_comb begin
      nextState = state;
      Busy      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               nextState = RUN;
            end
         end
         RUN: begin
            Busy = 1'b1;
            if (count == LAST_COUNT) begin
               nextState = FINISH;
            end
         end
         FINISH: begin
            Busy      = 1'b1;
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Datapath: latch operands on issue, iterate in RUN, and publish the
   // result with its strobes in FINISH. Strobes drop again after one cycle.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         opReg     <= '0;
         aLatched  <= '0;
         signA     <= 1'b0;
         signB     <= 1'b0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         rem       <= '0;
         quo       <= '0;
         divisor   <= '0;
         count     <= '0;
         Done      <= 1'b0;
         HiOut     <= '0;
         LoOut     <= '0;
         WriteEn   <= 1'b0;
         Madd      <= 1'b0;
         Msub      <= 1'b0;
         DivByZero <= 1'b0;
      end else begin
         Done      <= 1'b0;
         WriteEn   <= 1'b0;
         Madd      <= 1'b0;
         Msub      <= 1'b0;
         DivByZero <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  opReg    <= Op;
                  aLatched <= A;
                  signA    <= inSignA;
                  signB    <= inSignB;
                  acc      <= '0;
                  mcand    <= {{WIDTH{1'b0}}, magA};
                  mplier   <= magB;
                  rem      <= '0;
                  quo      <= magA;
                  divisor  <= magB;
                  count    <= '0;
               end
            end
            RUN: begin
               if (count != LAST_COUNT) begin
                  count <= count + 1'b1;
                  if (isDivOp) begin
                     if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                     end else begin
                        rem <= shifted[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                     end
                  end else begin
                     if (mplier[0]) begin
                        acc <= acc + mcand;
                     end
                     mcand  <= mcand << 1;
                     mplier <= mplier >> 1;
                  end
               end
            end
            FINISH: begin
               HiOut     <= resultHi;
               LoOut     <= resultLo;
               DivByZero <= resultDbz;
               Done      <= 1'b1;
               WriteEn   <= (opReg == OP_MULT) || (opReg == OP_MULTU) || isDivOp;
               Madd      <= (opReg == OP_MADD);
               Msub      <= (opReg == OP_MSUB);
            end
            default: begin
               count <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit. Directed cases plus random
// operations are checked against an arithmetic reference model.
module tb_hilo_muldiv_unit;

   logic        Clk;
   logic        Reset;
   logic        Start;
   logic [2:0]  Op;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic        Done;
   logic [31:0] HiOut;
   logic [31:0] LoOut;
   logic        WriteEn;
   logic        Madd;
   logic        Msub;
   logic        DivByZero;

   int compared;
   int mismatched;
   logic [31:0] lastHi;
   logic [31:0] lastLo;

   hilo_muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
      .Clk(Clk),
      .Reset(Reset),
      .Start(Start),
      .Op(Op),
      .A(A),
      .B(B),
      .Busy(Busy),
      .Done(Done),
      .HiOut(HiOut),
      .LoOut(LoOut),
      .WriteEn(WriteEn),
      .Madd(Madd),
      .Msub(Msub),
      .DivByZero(DivByZero)
   );

   // Free-running clock, 10 time units per cycle.
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Count one comparison and report it if it does not match.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Reference results from plain 64-bit arithmetic.
   task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic signed [63:0] sq;
      logic signed [63:0] sr;
      logic [63:0] p;
      sa  = $signed({{32{a[31]}}, a});
      sb  = $signed({{32{b[31]}}, b});
      dbz = 1'b0;
      hi  = '0;
      lo  = '0;
      case (op)
         3'd0, 3'd4, 3'd5: begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
         end
         3'd1: begin
            p  = {32'b0, a} * {32'b0, b};
            hi = p[63:32];
            lo = p[31:0];
         end
         3'd2: begin
            if (b == 0) begin
               dbz = 1'b1; hi = a; lo = '1;
            end else begin
               sq = sa / sb;
               sr = sa % sb;
               hi = sr[31:0];
               lo = sq[31:0];
            end
         end
         default: begin
            if (b == 0) begin
               dbz = 1'b1; hi = a; lo = '1;
            end else begin
               hi = a % b;
               lo = a / b;
            end
         end
      endcase
   endtask

   // Issue one operation at a negedge and follow it to Done. Optional noise
   // toggles Start/A/B/Op while busy; intrudeAt injects a MULT 9*9 Start.
   // Returns at the negedge of the Done cycle with Start low.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input bit noise, input int intrudeAt);
      logic [31:0] expHi;
      logic [31:0] expLo;
      logic        expDbz;
      int          cnt;
      bit          gotDone;
      bit          busyDrop;
      modelOp(op, a, b, expHi, expLo, expDbz);
      Start = 1'b1; Op = op; A = a; B = b;
      @(posedge Clk);
      #1;
      Start = 1'b0; A = $urandom; B = $urandom; Op = 3'($urandom_range(0, 7));
      @(negedge Clk);
      checkOutput("busy_after_start", {63'b0, Busy}, 64'd1);
      cnt = 0; gotDone = 0; busyDrop = 0;
      while (!gotDone && cnt < 60) begin
         @(posedge Clk);
         cnt++;
         @(negedge Clk);
         if (Done) begin
            gotDone = 1;
         end else begin
            if (!Busy) busyDrop = 1;
            if (noise) begin
               Start = ($urandom_range(0, 3) == 0);
               A = $urandom; B = $urandom; Op = 3'($urandom_range(0, 7));
            end
            if (cnt == intrudeAt) begin
               Start = 1'b1; Op = 3'd0; A = 32'd9; B = 32'd9;
            end else if (!noise) begin
               Start = 1'b0;
            end
         end
      end
      Start = 1'b0;
      if (!gotDone) begin
         checkOutput("done_timeout", 64'd0, 64'd1);
      end else begin
         checkOutput("latency", 64'(cnt), 64'd34);
         checkOutput("busy_held", {63'b0, busyDrop}, 64'd0);
         checkOutput("busy_low_in_done", {63'b0, Busy}, 64'd0);
         checkOutput("hi", {32'b0, HiOut}, {32'b0, expHi});
         checkOutput("lo", {32'b0, LoOut}, {32'b0, expLo});
         checkOutput("strobes", {61'b0, WriteEn, Madd, Msub},
                     {61'b0, (op <= 3'd3), (op == 3'd4), (op == 3'd5)});
         checkOutput("divbyzero", {63'b0, DivByZero}, {63'b0, expDbz});
      end
      lastHi = expHi;
      lastLo = expLo;
   endtask

   // One cycle after Done: pulses gone, results held.
   task automatic checkPulseEnd();
      @(negedge Clk);
      checkOutput("pulse_end", {60'b0, Done, WriteEn, Madd, Msub}, 64'd0);
      checkOutput("hold_result", {HiOut, LoOut}, {lastHi, lastLo});
   endtask

   initial begin
      bit strobeSeen;
      compared = 0; mismatched = 0;
      Start = 0; Op = 0; A = 0; B = 0;
      Reset = 0;
      #1 Reset = 1;
      #1;
      checkOutput("reset_outputs", {56'b0, Busy, Done, WriteEn, Madd, Msub, DivByZero, 2'b0}, 64'd0);
      checkOutput("reset_hilo", {HiOut, LoOut}, 64'd0);
      repeat (2) @(negedge Clk);
      Reset = 0;
      @(negedge Clk);

      $display("[TB] directed operations");
      applyStimulus(3'd0, 32'hFFFFFFFD, 32'd5, 0, -1);
      checkPulseEnd();
      applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, -1);
      checkPulseEnd();
      applyStimulus(3'd4, 32'd2, 32'd3, 0, -1);
      checkPulseEnd();
      applyStimulus(3'd2, 32'hFFFFFFF9, 32'd2, 0, -1);
      checkPulseEnd();
      applyStimulus(3'd3, 32'd7, 32'd2, 0, -1);
      checkPulseEnd();
      applyStimulus(3'd3, 32'h1234, 32'd0, 0, -1);
      checkPulseEnd();
      applyStimulus(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, -1);
      checkPulseEnd();
      applyStimulus(3'd2, 32'hFFFFFFF9, 32'd0, 0, -1);
      checkPulseEnd();

      $display("[TB] ignored start and back-to-back issue");
      applyStimulus(3'd5, 32'd4, 32'd4, 0, 10);
      applyStimulus(3'd0, 32'd9, 32'd9, 0, -1);
      checkPulseEnd();

      $display("[TB] illegal opcode");
      Start = 1; Op = 3'd6; A = 32'd5; B = 32'd5;
      @(negedge Clk);
      Op = 3'd7;
      @(negedge Clk);
      Start = 0;
      checkOutput("illegal_not_busy", {63'b0, Busy}, 64'd0);
      @(negedge Clk);
      checkOutput("illegal_no_done", {63'b0, Done}, 64'd0);

      $display("[TB] random operations");
      for (int i = 0; i < 40; i++) begin
         logic [2:0]  rop;
         logic [31:0] ra;
         logic [31:0] rb;
         rop = 3'($urandom_range(0, 5));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            2: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
            3: rb = {{16{rb[15]}}, rb[15:0]};
            default: ;
         endcase
         applyStimulus(rop, ra, rb, 1, -1);
         if ($urandom_range(0, 1) == 1) checkPulseEnd();
      end
      @(negedge Clk);

      $display("[TB] reset during operation");
      applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, -1);
      @(negedge Clk);
      Start = 1; Op = 3'd0; A = 32'h12345; B = 32'h777;
      @(posedge Clk);
      #1 Start = 0;
      repeat (15) @(posedge Clk);
      #2 Reset = 1;
      #1;
      checkOutput("midreset_outputs", {56'b0, Busy, Done, WriteEn, Madd, Msub, DivByZero, 2'b0}, 64'd0);
      checkOutput("midreset_hilo", {HiOut, LoOut}, 64'd0);
      repeat (2) @(negedge Clk);
      Reset = 0;
      strobeSeen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge Clk);
         if (Done || WriteEn || Madd || Msub || Busy) strobeSeen = 1;
      end
      checkOutput("no_activity_after_reset", {63'b0, strobeSeen}, 64'd0);
      applyStimulus(3'd0, 32'hFFFFFFFD, 32'd5, 0, -1);
      checkPulseEnd();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
